// File: rtl/sv_range_classifier.sv
// sv_range_classifier
//   Streaming classifier. Each accepted word is tested against NUM_RANGES
//   run-time programmable inclusive windows [lo:hi]. The word, its per-window
//   hit vector, an any-hit flag and the lowest hitting index are captured into
//   a single output register behind a valid/ready handshake.
//
// Parameters
//   DATA_W      width of data words and window bounds (unsigned)
//   NUM_RANGES  number of windows (>=1)
//   CNT_W       width of each hit counter
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cfg_we/idx/lo/hi/en       window table write port (idx >= NUM_RANGES ignored)
//   in_valid/in_ready/in_data input stream
//   out_valid/out_ready       output stream handshake
//   out_data                  classified word, passed through
//   out_hit_vec               bit i set when the word is inside enabled window i
//   out_any                   OR of out_hit_vec
//   out_first_idx             lowest set index of out_hit_vec, 0 when none
//   cnt_clr                   clear all hit counters
//   cnt_rd_idx/cnt_rd_val     combinational read of a registered hit counter
//
// Build option
//   RANGE_HIT_CNT_EN  defined: per-window saturating hit counters are built.
//                     undefined: no counters, cnt_rd_val reads 0.

module sv_range_classifier_win #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              hit
);
  // lo > hi can never satisfy both bounds, so such a window is simply empty.
  assign hit = en && (lo <= data) && (data <= hi);
endmodule

module sv_range_classifier #(
  parameter int DATA_W     = 8,
  parameter int NUM_RANGES = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_W-1:0]     cfg_lo,
  input  logic [DATA_W-1:0]     cfg_hi,
  input  logic                  cfg_en,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [NUM_RANGES-1:0] out_hit_vec,
  output logic                  out_any,
  output logic [IDX_W-1:0]      out_first_idx,
  input  logic                  cnt_clr,
  input  logic [IDX_W-1:0]      cnt_rd_idx,
  output logic [CNT_W-1:0]      cnt_rd_val
);

  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
  } win_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_RANGES-1:0] hit_vec;
    logic                  any;
    logic [IDX_W-1:0]      first_idx;
  } res_t;

  win_t [NUM_RANGES-1:0] win_tbl;
  logic [NUM_RANGES-1:0] hit;
  logic [IDX_W-1:0]      first_idx;
  logic                  in_xfer;
  res_t                  res_q;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Window table. Indices with no matching window never compare equal, so
  // out-of-range writes drop out without an explicit bound check.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_tbl <= '0;
    end else begin
      for (int i = 0; i < NUM_RANGES; i++)
        if (cfg_we && cfg_idx == IDX_W'(i))
          win_tbl[i] <= '{en: cfg_en, lo: cfg_lo, hi: cfg_hi};
    end
  end

  for (genvar g = 0; g < NUM_RANGES; g++) begin : g_win
    sv_range_classifier_win #(.DATA_W(DATA_W)) u_win (
      .lo   (win_tbl[g].lo),
      .hi   (win_tbl[g].hi),
      .en   (win_tbl[g].en),
      .data (in_data),
      .hit  (hit[g])
    );
  end

  // Priority encoder: scanning downward leaves the lowest hit index last.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_RANGES - 1; i >= 0; i--)
      if (hit[i]) first_idx = IDX_W'(i);
  end

  // Single output stage; a new word may replace the current one in the same
  // cycle it is taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      res_q     <= '{data: in_data, hit_vec: hit, any: |hit, first_idx: first_idx};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data      = res_q.data;
  assign out_hit_vec   = res_q.hit_vec;
  assign out_any       = res_q.any;
  assign out_first_idx = res_q.first_idx;

`ifdef RANGE_HIT_CNT_EN
  logic [NUM_RANGES-1:0][CNT_W-1:0] hit_cnt;

  // Clear takes priority over a coincident hit; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hit_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_RANGES; i++)
        if (in_xfer && hit[i] && hit_cnt[i] != '1)
          hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_rd_val = '0;
    for (int i = 0; i < NUM_RANGES; i++)
      if (cnt_rd_idx == IDX_W'(i)) cnt_rd_val = hit_cnt[i];
  end
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^{cnt_clr, cnt_rd_idx};
  assign cnt_rd_val    = '0;
`endif

endmodule

// File: tb/tb_sv_range_classifier.sv
module tb_sv_range_classifier;
  localparam int DW = 8, NR = 4, CW = 2, IW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_en, in_valid, in_ready, out_valid, out_ready, out_any, cnt_clr;
  logic [IW-1:0] cfg_idx, out_first_idx, cnt_rd_idx;
  logic [DW-1:0] cfg_lo, cfg_hi, in_data, out_data;
  logic [NR-1:0] out_hit_vec;
  logic [CW-1:0] cnt_rd_val;

  always #5 clk = ~clk;

  sv_range_classifier #(.DATA_W(DW), .NUM_RANGES(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_hit_vec(out_hit_vec), .out_any(out_any), .out_first_idx(out_first_idx),
    .cnt_clr(cnt_clr), .cnt_rd_idx(cnt_rd_idx), .cnt_rd_val(cnt_rd_val)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [NR-1:0] hv;
    logic          any;
    logic [IW-1:0] fi;
  } exp_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          we;
    logic [IW-1:0] widx;
    logic [DW-1:0] lo, hi;
    logic          en;
    logic          clr;
    logic [IW-1:0] rd;
  } stim_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;

  // Reference model state
  logic [DW-1:0] lo_m[NR], hi_m[NR];
  logic          en_m[NR];
  int            cnt_m[NR];
  logic          mv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t classify(input logic [DW-1:0] d);
    exp_t e;
    bit   found = 0;
    e.d  = d;
    e.hv = '0;
    e.fi = '0;
    for (int i = 0; i < NR; i++) begin
      if (en_m[i] && int'(lo_m[i]) <= int'(d) && int'(d) <= int'(hi_m[i])) begin
        e.hv[i] = 1'b1;
        if (!found) begin e.fi = IW'(i); found = 1; end
      end
    end
    e.any = found;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.iv = 0; s.d = '0; s.ordy = 1; s.we = 0; s.widx = '0;
    s.lo = '0; s.hi = '0; s.en = 0; s.clr = 0; s.rd = '0;
    return s;
  endfunction

  // One clock of stimulus: drive at negedge, check and update the model just after.
  task automatic step(input stim_t s);
    logic xfer;
    exp_t e;
    int   exp_cnt;
    @(negedge clk);
    in_valid = s.iv; in_data = s.d; out_ready = s.ordy;
    cfg_we = s.we; cfg_idx = s.widx; cfg_lo = s.lo; cfg_hi = s.hi; cfg_en = s.en;
    cnt_clr = s.clr; cnt_rd_idx = s.rd;
    #1;
    check("in_ready", 32'(in_ready), 32'(!mv || s.ordy));
    check("out_valid", 32'(out_valid), 32'(mv));
`ifdef RANGE_HIT_CNT_EN
    exp_cnt = cnt_m[s.rd];
`else
    exp_cnt = 0;
`endif
    check("cnt_rd_val", 32'(cnt_rd_val), exp_cnt);
    xfer = s.iv && (!mv || s.ordy);
    e = classify(s.d);
    if (xfer) sb.push_back(e);
    for (int i = 0; i < NR; i++) begin
      if (s.clr) cnt_m[i] = 0;
      else if (xfer && e.hv[i] && cnt_m[i] < CMAX) cnt_m[i]++;
    end
    if (s.we) begin
      lo_m[s.widx] = s.lo; hi_m[s.widx] = s.hi; en_m[s.widx] = s.en;
    end
    if (xfer) mv = 1;
    else if (mv && s.ordy) mv = 0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    stim_t s = idle();
    s.iv = 1; s.d = d;
    step(s);
  endtask

  task automatic wr(input int idx, input int lo, input int hi, input logic en);
    stim_t s = idle();
    s.we = 1; s.widx = IW'(idx); s.lo = DW'(lo); s.hi = DW'(hi); s.en = en;
    step(s);
  endtask

  // Monitor: pops the scoreboard whenever an output transfer is about to happen.
  logic          stalled = 0;
  logic [DW-1:0] pd;
  logic [NR-1:0] ph;
  logic          pa;
  logic [IW-1:0] pf;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled)
          check("stall_stable", 32'({out_data, out_hit_vec, out_any, out_first_idx}),
                32'({pd, ph, pa, pf}));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_empty: output word %0h with no expected entry", out_data);
          end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_hit_vec", 32'(out_hit_vec), 32'(e.hv));
            check("out_any", 32'(out_any), 32'(e.any));
            check("out_first_idx", 32'(out_first_idx), 32'(e.fi));
          end
        end
        stalled = out_valid && !out_ready;
        pd = out_data; ph = out_hit_vec; pa = out_any; pf = out_first_idx;
      end
    end
  end

  initial begin
    stim_t s;
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    // Reset, with a write and a valid word held on the inputs that must be ignored.
    rst = 1; in_valid = 1; in_data = 8'h05; out_ready = 1;
    cfg_we = 1; cfg_idx = '0; cfg_lo = 8'h00; cfg_hi = 8'hff; cfg_en = 1;
    cnt_clr = 0; cnt_rd_idx = '0;
    for (int i = 0; i < NR; i++) begin lo_m[i] = '0; hi_m[i] = '0; en_m[i] = 0; cnt_m[i] = 0; end
    mv = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_hit_vec", 32'(out_hit_vec), 0);
    check("rst_any", 32'(out_any), 0);
    check("rst_first_idx", 32'(out_first_idx), 0);
    check("rst_cnt", 32'(cnt_rd_val), 0);
    rst = 0; in_valid = 0; cfg_we = 0;

    // Unconfigured table: nothing hits.
    for (int v = 0; v < 256; v++) send(DW'(v));

    // Basic windows and overlap priority.
    wr(0, 3, 7, 1);
    wr(1, 5, 5, 1);
    wr(2, 10, 15, 1);
    send(2); send(5); send(9); send(12);

    // Empty window (lo > hi).
    wr(3, 20, 10, 1);
    send(15); send(20); send(10);

    // Write coinciding with an accepted word uses the old entry.
    s = idle(); s.iv = 1; s.d = 5; s.we = 1; s.widx = 0; s.lo = 0; s.hi = 0; s.en = 1;
    step(s);
    send(5);

    // Random traffic with backpressure and mid-stream reconfiguration.
    for (int k = 0; k < 1500; k++) begin
      s = idle();
      s.iv   = 1'($urandom_range(0, 1));
      s.d    = DW'($urandom);
      s.ordy = (k < 500) ? 1'(k % 2) : 1'($urandom_range(0, 3) != 0);
      s.rd   = IW'($urandom);
      s.clr  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) begin
        s.we = 1; s.widx = IW'($urandom);
        s.lo = DW'($urandom); s.hi = DW'($urandom_range(int'(s.lo), 255));
        if ($urandom_range(0, 7) == 0) s.hi = DW'($urandom);
        s.en = 1'($urandom_range(0, 1));
      end
      step(s);
    end

    // Counter saturation at CNT_W=2, then clear racing a hit.
    wr(0, 4, 4, 1);
    s = idle(); s.clr = 1; step(s);
    for (int k = 0; k < 5; k++) begin
      send(4);
      @(posedge clk); #1;
`ifdef RANGE_HIT_CNT_EN
      check("cnt_sat", 32'(cnt_rd_val), exp_sat[k]);
`else
      check("cnt_off", 32'(cnt_rd_val), 0);
`endif
    end
    s = idle(); s.iv = 1; s.d = 4; s.clr = 1; step(s);
    @(posedge clk); #1;
    check("cnt_clr_wins", 32'(cnt_rd_val), 0);

    // Drain and confirm every accepted word came out.
    repeat (4) step(idle());
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
